// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the multi-channel SDRAM burst scheduler.
package sdram_arb_pkg;

  localparam int DEF_NWR    = 2;
  localparam int DEF_NRD    = 2;
  localparam int DEF_ADDR_W = 23;
  localparam int DEF_LEN_W  = 9;
  localparam int DEF_LVL_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_WR_BUSY,
    ST_RD_BUSY
  } state_e;

  typedef enum logic {
    CLS_WR,
    CLS_RD
  } cls_e;

endpackage

// File: rtl/sdram_mc_arbiter_if.sv
// Burst request/acknowledge bus between the scheduler (master) and sdram_top (slave).
interface sdram_mc_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
);
  logic              sdram_wr_req;
  logic              sdram_wr_ack;
  logic [ADDR_W-1:0] sdram_wraddr;
  logic [LEN_W-1:0]  sdram_wr_len;
  logic              sdram_rd_req;
  logic              sdram_rd_ack;
  logic [ADDR_W-1:0] sdram_rdaddr;
  logic [LEN_W-1:0]  sdram_rd_len;

  modport master (
    output sdram_wr_req, sdram_wraddr, sdram_wr_len,
    output sdram_rd_req, sdram_rdaddr, sdram_rd_len,
    input  sdram_wr_ack, sdram_rd_ack
  );

  modport slave (
    input  sdram_wr_req, sdram_wraddr, sdram_wr_len,
    input  sdram_rd_req, sdram_rdaddr, sdram_rd_len,
    output sdram_wr_ack, sdram_rd_ack
  );
endinterface

// File: rtl/sdram_addr_gen.sv
// Per-channel address pointer: follows/reloads the start address, advances by the
// completed burst length and pulses frame_done_o when it wraps back to the start.
module sdram_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              track_i,
  input  logic              busy_i,
  input  logic              done_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] start_i,
  input  logic [ADDR_W-1:0] max_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              frame_done_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pend_q, pend_d;
  logic              frame_q, frame_d;
  logic [ADDR_W:0]   nxt;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    nxt     = {1'b0, ptr_q} + (ADDR_W + 1)'(len_i);
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    frame_d = 1'b0;
    if (done_i) begin
      pend_d = 1'b0;
      // A load requested during the burst beats the increment and suppresses the frame pulse.
      if (pend_q || load_i) begin
        ptr_d = start_i;
      end else if (nxt >= {1'b0, max_i}) begin
        ptr_d   = start_i;
        frame_d = 1'b1;
      end else begin
        ptr_d = nxt[ADDR_W-1:0];
      end
    end else if (busy_i) begin
      if (load_i) pend_d = 1'b1;
    end else if (track_i || load_i) begin
      ptr_d = start_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      pend_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
    end
  end

  assign ptr_o        = ptr_q;
  assign frame_done_o = frame_q;

endmodule

// File: rtl/sdram_mc_arbiter.sv
// Schedules one SDRAM burst at a time across NWR write and NRD read channels,
// alternating class priority and round-robin within each class.
module sdram_mc_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NWR    = DEF_NWR,
  parameter int NRD    = DEF_NRD,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int LVL_W  = DEF_LVL_W
) (
  input  logic                  clk_ref,
  input  logic                  rst,
  input  logic                  sdram_init_done,
  input  logic [NWR*LVL_W-1:0]  wr_level,
  input  logic [NWR*LEN_W-1:0]  wr_length,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*ADDR_W-1:0] wr_max_addr,
  input  logic [NWR-1:0]        wr_load,
  input  logic [NRD*LVL_W-1:0]  rd_space,
  input  logic [NRD*LEN_W-1:0]  rd_length,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  input  logic [NRD*ADDR_W-1:0] rd_max_addr,
  input  logic [NRD-1:0]        rd_load,
  sdram_mc_arbiter_if.master    sdram,
  output logic [NWR-1:0]        wr_grant,
  output logic [NRD-1:0]        rd_grant,
  output logic [NWR-1:0]        frame_write_done,
  output logic [NRD-1:0]        frame_read_done
);

  localparam int WIX_W = (NWR > 1) ? $clog2(NWR) : 1;
  localparam int RIX_W = (NRD > 1) ? $clog2(NRD) : 1;
  localparam int CMP_W = (LVL_W > LEN_W) ? LVL_W : LEN_W;

  state_e            state_q, state_d;
  cls_e              pref_q, pref_d;
  logic [NWR-1:0]    wr_grant_q, wr_grant_d, wr_elig;
  logic [NRD-1:0]    rd_grant_q, rd_grant_d, rd_elig;
  logic [WIX_W-1:0]  wr_last_q, wr_last_d, wr_pick;
  logic [RIX_W-1:0]  rd_last_q, rd_last_d, rd_pick;
  logic              wr_found, rd_found, wr_done, rd_done;
  logic              wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] wraddr_q, wraddr_d, rdaddr_q, rdaddr_d;
  logic [LEN_W-1:0]  wr_len_q, wr_len_d, rd_len_q, rd_len_d;
  logic [ADDR_W-1:0] wr_ptr [NWR];
  logic [ADDR_W-1:0] rd_ptr [NRD];
  logic [LEN_W-1:0]  wr_len_a [NWR];
  logic [LEN_W-1:0]  rd_len_a [NRD];

  for (genvar i = 0; i < NWR; i++) begin : g_wr
    logic [LVL_W-1:0] lvl;
    assign lvl         = wr_level[i*LVL_W +: LVL_W];
    assign wr_len_a[i] = wr_length[i*LEN_W +: LEN_W];
    assign wr_elig[i]  = (wr_len_a[i] != '0) && (CMP_W'(lvl) >= CMP_W'(wr_len_a[i]));
    sdram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_gen (
      .clk_ref(clk_ref), .rst(rst), .track_i(!sdram_init_done),
      .busy_i(wr_grant_q[i] | wr_grant_d[i]), .done_i(wr_done & wr_grant_q[i]),
      .load_i(wr_load[i]), .start_i(wr_addr[i*ADDR_W +: ADDR_W]),
      .max_i(wr_max_addr[i*ADDR_W +: ADDR_W]), .len_i(wr_len_q),
      .ptr_o(wr_ptr[i]), .frame_done_o(frame_write_done[i])
    );
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [LVL_W-1:0] spc;
    assign spc         = rd_space[j*LVL_W +: LVL_W];
    assign rd_len_a[j] = rd_length[j*LEN_W +: LEN_W];
    assign rd_elig[j]  = (rd_len_a[j] != '0) && (CMP_W'(spc) >= CMP_W'(rd_len_a[j]));
    sdram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_gen (
      .clk_ref(clk_ref), .rst(rst), .track_i(!sdram_init_done),
      .busy_i(rd_grant_q[j] | rd_grant_d[j]), .done_i(rd_done & rd_grant_q[j]),
      .load_i(rd_load[j]), .start_i(rd_addr[j*ADDR_W +: ADDR_W]),
      .max_i(rd_max_addr[j*ADDR_W +: ADDR_W]), .len_i(rd_len_q),
      .ptr_o(rd_ptr[j]), .frame_done_o(frame_read_done[j])
    );
  end

  // Round-robin search begins one past the channel granted last in each class.
  always_comb begin
    int widx, ridx;
    widx     = 0;
    ridx     = 0;
    wr_found = 1'b0;
    wr_pick  = '0;
    rd_found = 1'b0;
    rd_pick  = '0;
    for (int k = 1; k <= NWR; k++) begin
      widx = (int'(wr_last_q) + k) % NWR;
      if (!wr_found && wr_elig[widx]) begin
        wr_found = 1'b1;
        wr_pick  = WIX_W'(widx);
      end
    end
    for (int k = 1; k <= NRD; k++) begin
      ridx = (int'(rd_last_q) + k) % NRD;
      if (!rd_found && rd_elig[ridx]) begin
        rd_found = 1'b1;
        rd_pick  = RIX_W'(ridx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pref_d     = pref_q;
    wr_grant_d = wr_grant_q;
    rd_grant_d = rd_grant_q;
    wr_last_d  = wr_last_q;
    rd_last_d  = rd_last_q;
    wr_req_d   = wr_req_q;
    rd_req_d   = rd_req_q;
    wraddr_d   = wraddr_q;
    rdaddr_d   = rdaddr_q;
    wr_len_d   = wr_len_q;
    rd_len_d   = rd_len_q;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (sdram_init_done && (|wr_elig || |rd_elig)) state_d = ST_ARB;
      ST_ARB: begin
        if (wr_found && (pref_q == CLS_WR || !rd_found)) begin
          state_d             = ST_WR_REQ;
          wr_req_d            = 1'b1;
          wr_grant_d          = '0;
          wr_grant_d[wr_pick] = 1'b1;
          wr_last_d           = wr_pick;
          wraddr_d            = wr_ptr[wr_pick];
          wr_len_d            = wr_len_a[wr_pick];
        end else if (rd_found) begin
          state_d             = ST_RD_REQ;
          rd_req_d            = 1'b1;
          rd_grant_d          = '0;
          rd_grant_d[rd_pick] = 1'b1;
          rd_last_d           = rd_pick;
          rdaddr_d            = rd_ptr[rd_pick];
          rd_len_d            = rd_len_a[rd_pick];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ: if (sdram.sdram_wr_ack) begin
        wr_req_d = 1'b0;
        state_d  = ST_WR_BUSY;
      end
      ST_RD_REQ: if (sdram.sdram_rd_ack) begin
        rd_req_d = 1'b0;
        state_d  = ST_RD_BUSY;
      end
      ST_WR_BUSY: if (!sdram.sdram_wr_ack) begin
        wr_done    = 1'b1;
        wr_grant_d = '0;
        pref_d     = (pref_q == CLS_WR) ? CLS_RD : CLS_WR;
        state_d    = ST_IDLE;
      end
      ST_RD_BUSY: if (!sdram.sdram_rd_ack) begin
        rd_done    = 1'b1;
        rd_grant_d = '0;
        pref_d     = (pref_q == CLS_WR) ? CLS_RD : CLS_WR;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pref_q     <= CLS_WR;
      wr_grant_q <= '0;
      rd_grant_q <= '0;
      wr_last_q  <= WIX_W'(NWR - 1);
      rd_last_q  <= RIX_W'(NRD - 1);
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      wraddr_q   <= '0;
      rdaddr_q   <= '0;
      wr_len_q   <= '0;
      rd_len_q   <= '0;
    end else begin
      state_q    <= state_d;
      pref_q     <= pref_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      wr_last_q  <= wr_last_d;
      rd_last_q  <= rd_last_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      wraddr_q   <= wraddr_d;
      rdaddr_q   <= rdaddr_d;
      wr_len_q   <= wr_len_d;
      rd_len_q   <= rd_len_d;
    end
  end

  assign sdram.sdram_wr_req = wr_req_q;
  assign sdram.sdram_wraddr = wraddr_q;
  assign sdram.sdram_wr_len = wr_len_q;
  assign sdram.sdram_rd_req = rd_req_q;
  assign sdram.sdram_rdaddr = rdaddr_q;
  assign sdram.sdram_rd_len = rd_len_q;
  assign wr_grant           = wr_grant_q;
  assign rd_grant           = rd_grant_q;

endmodule
